mdu_hilo: RTL and testbench

Multiply/divide unit with HI/LO registers for the pipelined MIPS core. It sits in the execute stage directly downstream of `GPR`: it takes `GPR` read-port operands (rs/rt), runs a multi-cycle mult/div, and holds results in HI/LO. `mfhi`/`mflo` read those results and write them back through `GPR`'s write port. `Busy` drives the hazard unit's stall for later HI/LO-touching instructions.

---
 rtl/mdu_hilo.sv | 125 ++++++++++++
 tb/tb_mdu_hilo.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_hilo.sv
// Multi-cycle multiply/divide unit holding results in HI/LO for the execute stage.
// Define MDU_MADD_EN to enable madd/maddu (Op 100/101) and build the 64-bit accumulate adder.
module mdu_hilo #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        Clk,
   input  logic        Rst,
   input  logic        Start,
   input  logic [2:0]  Op,
   input  logic [31:0] D1,
   input  logic [31:0] D2,
   input  logic        HiWe,
   input  logic        LoWe,
   output logic        Busy,
   output logic [31:0] Hi,
   output logic [31:0] Lo
);

   // Busy is the state bit itself: IDLE=0, RUN=1.
   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [2:0]  op_q, op_d;
   logic [31:0] a_q, a_d, b_q, b_d;
   logic [31:0] hi_q, hi_d, lo_q, lo_d;

   logic        op_valid, is_div, sgn, neg_a, neg_b;
   logic [63:0] ext_a, ext_b, prod, res;
   logic [31:0] abs_a, abs_b, den, quo_u, rem_u, quo, rem;

   always_comb begin
      op_valid = (Op[2] == 1'b0);
`ifdef MDU_MADD_EN
      if (Op[2:1] == 2'b10) op_valid = 1'b1;
`endif
   end

   // Lower 64 bits of the extended product are correct for both signednesses.
   always_comb begin
      is_div = (op_q[2:1] == 2'b01);
      sgn    = ~op_q[0];
      ext_a  = {{32{sgn & a_q[31]}}, a_q};
      ext_b  = {{32{sgn & b_q[31]}}, b_q};
      prod   = ext_a * ext_b;
      neg_a  = sgn & a_q[31];
      neg_b  = sgn & b_q[31];
      abs_a  = neg_a ? (~a_q + 32'd1) : a_q;
      abs_b  = neg_b ? (~b_q + 32'd1) : b_q;
      den    = (b_q == 32'd0) ? 32'd1 : abs_b;
      quo_u  = abs_a / den;
      rem_u  = abs_a % den;
      quo    = (neg_a ^ neg_b) ? (~quo_u + 32'd1) : quo_u;
      rem    = neg_a ? (~rem_u + 32'd1) : rem_u;
      res    = prod;
      if (is_div) res = {rem, quo};
`ifdef MDU_MADD_EN
      else if (op_q[2:1] == 2'b10) res = {hi_q, lo_q} + prod;
`endif
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         op_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      case (state_q)
         IDLE: begin
            if (Start) begin
               if (op_valid) begin
                  state_d = RUN;
                  op_d    = Op;
                  a_d     = D1;
                  b_d     = D2;
                  cnt_d   = (Op[2:1] == 2'b01) ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
               end
            end else begin
               if (HiWe) hi_d = D1;
               if (LoWe) lo_d = D1;
            end
         end
         RUN: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q <= 4'd1) begin
               state_d = IDLE;
               cnt_d   = '0;
               // Divide by zero still spends its full latency but commits nothing.
               if (!(is_div && (b_q == 32'd0))) {hi_d, lo_d} = res;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      Busy = (state_q == RUN);
      Hi   = hi_q;
      Lo   = lo_q;
   end

endmodule

// File: tb/tb_mdu_hilo.sv
// Self-checking bench for mdu_hilo: directed scenarios plus randomized ops
// against a 64-bit arithmetic reference model of HI/LO.
module tb_mdu_hilo;

   localparam int MULT_N = 5;
   localparam int DIV_N  = 10;
`ifdef MDU_MADD_EN
   localparam bit MADD = 1'b1;
`else
   localparam bit MADD = 1'b0;
`endif

   logic        Clk = 1'b0;
   logic        Rst = 1'b1;
   logic        Start = 1'b0;
   logic [2:0]  Op = '0;
   logic [31:0] D1 = '0;
   logic [31:0] D2 = '0;
   logic        HiWe = 1'b0;
   logic        LoWe = 1'b0;
   logic        Busy;
   logic [31:0] Hi, Lo;

   int errors = 0;
   int checks = 0;
   logic [31:0] m_hi = '0;
   logic [31:0] m_lo = '0;

   mdu_hilo #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
      .Clk(Clk), .Rst(Rst), .Start(Start), .Op(Op), .D1(D1), .D2(D2),
      .HiWe(HiWe), .LoWe(LoWe), .Busy(Busy), .Hi(Hi), .Lo(Lo)
   );

   always #5 Clk = ~Clk;

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   // Reference: MIPS semantics computed with plain 64-bit integer arithmetic.
   task automatic model_apply(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      longint          sa, sb, sp;
      longint unsigned ua, ub, up;
      sa = $signed(a);
      sb = $signed(b);
      ua = {32'd0, a};
      ub = {32'd0, b};
      case (op)
         3'd0: begin sp = sa * sb; {m_hi, m_lo} = sp; end
         3'd1: begin up = ua * ub; {m_hi, m_lo} = up; end
         3'd2: if (b != 32'd0) begin m_lo = 32'(sa / sb); m_hi = 32'(sa % sb); end
         3'd3: if (b != 32'd0) begin m_lo = 32'(ua / ub); m_hi = 32'(ua % ub); end
         3'd4: begin sp = sa * sb; {m_hi, m_lo} = {m_hi, m_lo} + sp; end
         3'd5: begin up = ua * ub; {m_hi, m_lo} = {m_hi, m_lo} + up; end
         default: ;
      endcase
   endtask

   function automatic bit op_ok(input logic [2:0] op);
      return (op < 3'd4) || (MADD && op < 3'd6);
   endfunction

   task automatic check_hilo(input string name);
      checks++;
      if (Hi !== m_hi) begin
         errors++;
         $display("FAIL %s hi: got %h expected %h", name, Hi, m_hi);
      end
      checks++;
      if (Lo !== m_lo) begin
         errors++;
         $display("FAIL %s lo: got %h expected %h", name, Lo, m_lo);
      end
   endtask

   task automatic write_hilo(input logic hwe, input logic lwe, input logic [31:0] d, input string name);
      HiWe = hwe; LoWe = lwe; D1 = d;
      tick();
      HiWe = 1'b0; LoWe = 1'b0;
      if (hwe) m_hi = d;
      if (lwe) m_lo = d;
      check_hilo(name);
   endtask

   // Launch a valid op; optionally also strobe HiWe/LoWe with Start, and
   // optionally inject Start/HiWe/LoWe plus new operands during busy cycle inject_at.
   task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] we, input int inject_at, input string name);
      int cyc;
      int exp_cyc;
      logic [31:0] old_hi, old_lo;
      exp_cyc = (op[2:1] == 2'b01) ? DIV_N : MULT_N;
      old_hi = m_hi;
      old_lo = m_lo;
      Start = 1'b1; Op = op; D1 = a; D2 = b; HiWe = we[1]; LoWe = we[0];
      tick();
      Start = 1'b0; HiWe = 1'b0; LoWe = 1'b0;
      cyc = 0;
      while (Busy === 1'b1 && cyc < 40) begin
         cyc++;
         if (cyc == exp_cyc) begin
            checks++;
            if (Hi !== old_hi || Lo !== old_lo) begin
               errors++;
               $display("FAIL %s early_commit: got %h_%h expected %h_%h", name, Hi, Lo, old_hi, old_lo);
            end
         end
         if (cyc == inject_at) begin
            Start = 1'b1; Op = 3'd0; D1 = $urandom; D2 = $urandom; HiWe = 1'b1; LoWe = 1'b1;
         end
         tick();
         Start = 1'b0; HiWe = 1'b0; LoWe = 1'b0;
      end
      model_apply(op, a, b);
      checks++;
      if (cyc != exp_cyc) begin
         errors++;
         $display("FAIL %s busy_cycles: got %0d expected %0d", name, cyc, exp_cyc);
      end
      check_hilo(name);
   endtask

   task automatic run_reserved(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input string name);
      Start = 1'b1; Op = op; D1 = a; D2 = b; HiWe = 1'b1; LoWe = 1'b1;
      tick();
      Start = 1'b0; HiWe = 1'b0; LoWe = 1'b0;
      checks++;
      if (Busy !== 1'b0) begin
         errors++;
         $display("FAIL %s busy: got %b expected 0", name, Busy);
      end
      check_hilo(name);
   endtask

   task automatic test_reset();
      #2;
      checks++;
      if (Busy !== 1'b0) begin
         errors++;
         $display("FAIL reset busy: got %b expected 0", Busy);
      end
      check_hilo("reset");
      tick();
      Rst = 1'b0;
      tick();
   endtask

   task automatic test_mult();
      run_op(3'd0, 32'hFFFF_FFFF, 32'd2, 2'b00, 0, "mult");
      run_op(3'd1, 32'hFFFF_FFFF, 32'd2, 2'b00, 0, "multu");
      run_op(3'd0, 32'h8000_0000, 32'h8000_0000, 2'b00, 0, "mult_minmin");
   endtask

   task automatic test_div();
      run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 2'b00, 0, "div_neg");
      run_op(3'd3, 32'd7, 32'd2, 2'b00, 0, "divu");
      run_op(3'd2, 32'h0000_0007, 32'hFFFF_FFFE, 2'b00, 0, "div_negdivisor");
      run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 2'b00, 0, "div_overflow");
   endtask

   task automatic test_div_zero();
      write_hilo(1'b1, 1'b0, 32'h0000_BEEF, "mthi");
      write_hilo(1'b0, 1'b1, 32'h0000_1234, "mtlo");
      run_op(3'd2, 32'd55, 32'd0, 2'b00, 0, "div_zero");
      run_op(3'd3, 32'd55, 32'd0, 2'b00, 0, "divu_zero");
      run_op(3'd2, 32'd1000, 32'd7, 2'b00, 3, "div_start_in_run");
      run_op(3'd0, 32'd1234, 32'd5678, 2'b00, 2, "mult_start_in_run");
   endtask

   task automatic test_start_wins();
      write_hilo(1'b1, 1'b1, 32'h1111_1111, "mthilo_both");
      run_op(3'd0, 32'hAAAA_0000, 32'd1, 2'b10, 0, "start_hiwe");
      run_op(3'd1, 32'h0000_0003, 32'd3, 2'b11, 0, "start_hilowe");
      run_reserved(3'd6, 32'hDEAD_0000, 32'd1, "reserved6");
   endtask

   task automatic test_madd();
      write_hilo(1'b1, 1'b0, 32'd0, "madd_mthi");
      write_hilo(1'b0, 1'b1, 32'h10, "madd_mtlo");
      if (MADD) begin
         run_op(3'd4, 32'd3, 32'd4, 2'b00, 0, "madd");
         run_op(3'd4, 32'hFFFF_FFFF, 32'd100, 2'b00, 0, "madd_neg");
         run_op(3'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00, 0, "maddu");
      end else begin
         run_reserved(3'd4, 32'd3, 32'd4, "madd_off");
         run_reserved(3'd5, 32'd3, 32'd4, "maddu_off");
      end
   endtask

   task automatic test_back_to_back();
      run_op(3'd3, 32'd100, 32'd9, 2'b00, 0, "b2b_divu");
      run_op(3'd0, 32'hFFFF_FFF0, 32'd3, 2'b00, 0, "b2b_mult");
      run_op(3'd2, 32'hFFFF_FF00, 32'd16, 2'b00, 0, "b2b_div");
   endtask

   task automatic test_rst_mid();
      write_hilo(1'b1, 1'b1, 32'h5555_AAAA, "pre_rst");
      Start = 1'b1; Op = 3'd2; D1 = 32'd100; D2 = 32'd7;
      tick();
      Start = 1'b0;
      tick();
      tick();
      checks++;
      if (Busy !== 1'b1) begin
         errors++;
         $display("FAIL rst_mid busy_before: got %b expected 1", Busy);
      end
      #2 Rst = 1'b1;
      #1;
      m_hi = '0;
      m_lo = '0;
      checks++;
      if (Busy !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid busy: got %b expected 0", Busy);
      end
      check_hilo("rst_mid");
      tick();
      Rst = 1'b0;
      tick();
      run_op(3'd1, 32'h0001_0000, 32'h0001_0000, 2'b00, 0, "after_rst");
   endtask

   task automatic test_random();
      logic [2:0]  op;
      logic [31:0] a, b;
      int          r;
      for (int i = 0; i < 40; i++) begin
         r = $urandom_range(0, 9);
         a = $urandom;
         b = $urandom;
         if ($urandom_range(0, 7) == 0) b = 32'd0;
         if ($urandom_range(0, 9) == 0) b = 32'($urandom_range(1, 5));
         if (r < 2) begin
            write_hilo(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, "rand_mt");
         end else begin
            op = 3'($urandom_range(0, 7));
            if (op_ok(op))
               run_op(op, a, b, 2'($urandom_range(0, 3)), $urandom_range(0, 4), "rand_op");
            else
               run_reserved(op, a, b, "rand_reserved");
         end
      end
   endtask

   initial begin
      test_reset();
      test_mult();
      test_div();
      test_div_zero();
      test_start_wins();
      test_madd();
      test_back_to_back();
      test_rst_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
